// File: rtl/redmule_tcdm_arbiter_if.sv
// Bundle of streamer-side and TCDM-side bus signals around the RedMulE TCDM arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface redmule_tcdm_arbiter_if #(
  parameter int unsigned DATA_W = 288,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned N_REQ  = 4
);
  logic [N_REQ-1:0]          req_i;
  logic [N_REQ-1:0]          wen_i;
  logic [N_REQ*ADDR_W-1:0]   addr_i;
  logic [N_REQ*DATA_W/8-1:0] be_i;
  logic [N_REQ*DATA_W-1:0]   wdata_i;
  logic [N_REQ-1:0]          gnt_o;
  logic [N_REQ-1:0]          r_valid_o;
  logic [DATA_W-1:0]         r_data_o;

  logic                      tcdm_req_o;
  logic                      tcdm_gnt_i;
  logic                      tcdm_wen_o;
  logic [ADDR_W-1:0]         tcdm_add_o;
  logic [DATA_W/8-1:0]       tcdm_be_o;
  logic [DATA_W-1:0]         tcdm_data_o;
  logic                      tcdm_r_valid_i;
  logic [DATA_W-1:0]         tcdm_r_data_i;

  modport slave (
    input  req_i, wen_i, addr_i, be_i, wdata_i,
    output gnt_o, r_valid_o, r_data_o,
    output tcdm_req_o, tcdm_wen_o, tcdm_add_o, tcdm_be_o, tcdm_data_o,
    input  tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_data_i
  );

  modport master (
    output req_i, wen_i, addr_i, be_i, wdata_i,
    input  gnt_o, r_valid_o, r_data_o,
    input  tcdm_req_o, tcdm_wen_o, tcdm_add_o, tcdm_be_o, tcdm_data_o,
    output tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_data_i
  );
endinterface

// File: rtl/redmule_tcdm_arbiter.sv
// Shares the wide TCDM port between the X/W/Y/Z streamers: round-robin with starvation
// escalation, a stall lock, and an in-order ID FIFO steering read data to its issuer.
module redmule_tcdm_arbiter #(
  parameter int unsigned DATA_W     = 288,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  redmule_tcdm_arbiter_if.slave      bus,
  output logic [$clog2(MAX_OUTST):0] outst_cnt_o,
  output logic                       busy_o,
  output logic                       err_o
);
  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTST) + 1;
  localparam int unsigned WAIT_W = $clog2(STARVE_LIM + 1);
  localparam int unsigned BE_W   = DATA_W / 8;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  locked_idx;
  logic [IDX_W-1:0]  sel;
  logic              lock;
  logic              found;
  int                scan_idx;
  logic [WAIT_W-1:0] wait_cnt [N_REQ];
  logic [IDX_W-1:0]  id_mem [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [N_REQ-1:0]  eligible;
  logic              handshake;
  logic              push;
  logic              pop;

  assign fifo_full  = (fifo_cnt == CNT_W'(MAX_OUTST));
  assign fifo_empty = (fifo_cnt == '0);
  // Reads stay masked on a full FIFO even when a response frees a slot this cycle.
  assign eligible   = bus.req_i & {N_REQ{enable_i}} & ~(bus.wen_i & {N_REQ{fifo_full}});

  always_comb begin
    sel      = '0;
    found    = 1'b0;
    scan_idx = 0;
    if (lock) begin
      sel   = locked_idx;
      found = 1'b1;
    end else begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (!found && eligible[i] && (wait_cnt[i] >= WAIT_W'(STARVE_LIM))) begin
          sel   = IDX_W'(i);
          found = 1'b1;
        end
      end
      for (int j = 0; j < int'(N_REQ); j++) begin
        scan_idx = int'(rr_ptr) + j;
        if (scan_idx >= int'(N_REQ)) scan_idx = scan_idx - int'(N_REQ);
        if (!found && eligible[scan_idx[IDX_W-1:0]]) begin
          sel   = scan_idx[IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
  end

  assign bus.tcdm_req_o  = lock | (|eligible);
  assign bus.tcdm_wen_o  = bus.wen_i[sel];
  assign bus.tcdm_add_o  = bus.addr_i[sel*ADDR_W +: ADDR_W];
  assign bus.tcdm_be_o   = bus.be_i[sel*BE_W +: BE_W];
  assign bus.tcdm_data_o = bus.wdata_i[sel*DATA_W +: DATA_W];
  assign bus.r_data_o    = bus.tcdm_r_data_i;

  assign handshake = bus.tcdm_req_o & bus.tcdm_gnt_i;
  assign push      = handshake & bus.tcdm_wen_o;
  assign pop       = bus.tcdm_r_valid_i & ~fifo_empty;

  always_comb begin
    bus.gnt_o = '0;
    if (handshake) bus.gnt_o[sel] = 1'b1;
  end

  always_comb begin
    bus.r_valid_o = '0;
    if (pop) bus.r_valid_o[id_mem[rd_ptr]] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr] <= sel;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock       <= 1'b0;
      locked_idx <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      err_o      <= 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) wait_cnt[i] <= '0;
    end else begin
      if (handshake) begin
        rr_ptr <= (sel == IDX_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
        lock   <= 1'b0;
      end else if (bus.tcdm_req_o) begin
        lock       <= 1'b1;
        locked_idx <= sel;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      if (bus.tcdm_r_valid_i && fifo_empty) err_o <= 1'b1;
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (!bus.req_i[i] || (handshake && (sel == IDX_W'(i)))) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] < WAIT_W'(STARVE_LIM)) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign outst_cnt_o = fifo_cnt;
  assign busy_o      = bus.tcdm_req_o | (fifo_cnt != '0);
endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// Self-checking bench for redmule_tcdm_arbiter: directed scenarios with literal expectations
// plus a long randomized run compared every cycle against a queue-based behavioural model.
module tb_redmule_tcdm_arbiter;
  localparam int DATA_W     = 288;
  localparam int ADDR_W     = 32;
  localparam int N_REQ      = 4;
  localparam int MAX_OUTST  = 4;
  localparam int STARVE_LIM = 8;
  localparam int BE_W       = DATA_W / 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] outst_cnt;
  logic       busy;
  logic       err;

  logic [ADDR_W-1:0] s_addr  [N_REQ];
  logic [BE_W-1:0]   s_be    [N_REQ];
  logic [DATA_W-1:0] s_wdata [N_REQ];

  redmule_tcdm_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_REQ(N_REQ)) bus ();

  for (genvar g = 0; g < N_REQ; g++) begin : g_pack
    assign bus.addr_i[g*ADDR_W +: ADDR_W]  = s_addr[g];
    assign bus.be_i[g*BE_W +: BE_W]        = s_be[g];
    assign bus.wdata_i[g*DATA_W +: DATA_W] = s_wdata[g];
  end

  redmule_tcdm_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_REQ(N_REQ),
    .MAX_OUTST(MAX_OUTST), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .bus         (bus),
    .outst_cnt_o (outst_cnt),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: arbitration bookkeeping plus a queue of issuers of outstanding reads.
  int   m_rr;
  int   m_lidx;
  bit   m_lock;
  int   m_wait [N_REQ];
  int   m_q [$];
  bit   m_err;
  logic [N_REQ-1:0] last_gnt;

  task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_wide();
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < DATA_W / 32; k++) r = {r[DATA_W-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_lidx = 0; m_lock = 0; m_err = 0;
    m_q.delete();
    for (int i = 0; i < N_REQ; i++) m_wait[i] = 0;
    last_gnt = '0;
  endtask

  // Wait to mid-cycle, compare every output against the model, then advance the model.
  task automatic settle();
    bit full, found, treq, hs;
    logic [N_REQ-1:0] elig, e_gnt, e_rv;
    int sel, k;
    #4;
    full = (m_q.size() == MAX_OUTST);
    for (int i = 0; i < N_REQ; i++)
      elig[i] = bus.req_i[i] & enable & ~(bus.wen_i[i] & full);
    sel = 0; found = 0;
    if (m_lock) begin
      sel = m_lidx; found = 1;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (!found && elig[i] && m_wait[i] >= STARVE_LIM) begin sel = i; found = 1; end
      for (int j = 0; j < N_REQ; j++) begin
        k = (m_rr + j) % N_REQ;
        if (!found && elig[k]) begin sel = k; found = 1; end
      end
    end
    treq  = m_lock || (elig != '0);
    hs    = treq && bus.tcdm_gnt_i;
    e_gnt = hs ? N_REQ'(1 << sel) : '0;
    e_rv  = (bus.tcdm_r_valid_i && m_q.size() > 0) ? N_REQ'(1 << m_q[0]) : '0;

    check_output("gnt_o", DATA_W'(bus.gnt_o), DATA_W'(e_gnt));
    check_output("r_valid_o", DATA_W'(bus.r_valid_o), DATA_W'(e_rv));
    check_output("tcdm_req_o", DATA_W'(bus.tcdm_req_o), DATA_W'(treq));
    check_output("outst_cnt_o", DATA_W'(outst_cnt), DATA_W'(m_q.size()));
    check_output("busy_o", DATA_W'(busy), DATA_W'(treq || m_q.size() != 0));
    check_output("err_o", DATA_W'(err), DATA_W'(m_err));
    if (treq) begin
      check_output("tcdm_add_o", DATA_W'(bus.tcdm_add_o), DATA_W'(s_addr[sel]));
      check_output("tcdm_wen_o", DATA_W'(bus.tcdm_wen_o), DATA_W'(bus.wen_i[sel]));
      check_output("tcdm_be_o", DATA_W'(bus.tcdm_be_o), DATA_W'(s_be[sel]));
      check_output("tcdm_data_o", bus.tcdm_data_o, s_wdata[sel]);
    end
    if (e_rv != '0) check_output("r_data_o", bus.r_data_o, bus.tcdm_r_data_i);

    for (int i = 0; i < N_REQ; i++) begin
      if (!bus.req_i[i] || (hs && i == sel)) m_wait[i] = 0;
      else if (m_wait[i] < STARVE_LIM) m_wait[i]++;
    end
    if (bus.tcdm_r_valid_i) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1;
    end
    if (hs) begin
      m_rr = (sel + 1) % N_REQ;
      m_lock = 0;
      if (bus.wen_i[sel]) m_q.push_back(sel);
    end else if (treq) begin
      m_lock = 1; m_lidx = sel;
    end
    last_gnt = e_gnt;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_i = '0; bus.wen_i = '0;
    bus.tcdm_gnt_i = 1'b0; bus.tcdm_r_valid_i = 1'b0; bus.tcdm_r_data_i = '0;
    enable = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      s_addr[i] = ADDR_W'(i * 16); s_be[i] = '0; s_wdata[i] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic apply_stimulus(input int i, input bit wen, input logic [ADDR_W-1:0] addr);
    bus.req_i[i] = 1'b1;
    bus.wen_i[i] = wen;
    s_addr[i]    = addr;
    s_be[i]      = {BE_W{1'b1}} ^ BE_W'(i);
    s_wdata[i]   = {9{32'hC0DE_0000 | 32'(i)}};
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [N_REQ-1:0]  rr_exp [5];
    bit               pend [N_REQ];
    int                gnt_pct;

    rst = 1'b1;
    clear_inputs();
    model_reset();

    // Single read
    do_reset();
    settle();
    check_output("reset_cnt", DATA_W'(outst_cnt), DATA_W'(0));
    check_output("reset_req", DATA_W'(bus.tcdm_req_o), DATA_W'(0));
    advance();
    apply_stimulus(0, 1'b1, 32'h100);
    bus.tcdm_gnt_i = 1'b1;
    settle();
    check_output("single_gnt", DATA_W'(bus.gnt_o), DATA_W'(4'b0001));
    check_output("single_cnt0", DATA_W'(outst_cnt), DATA_W'(0));
    advance();
    d = {9{32'hA5A5_0001}};
    bus.req_i = '0; bus.tcdm_gnt_i = 1'b0;
    bus.tcdm_r_valid_i = 1'b1; bus.tcdm_r_data_i = d;
    settle();
    check_output("single_rvalid", DATA_W'(bus.r_valid_o), DATA_W'(4'b0001));
    check_output("single_rdata", bus.r_data_o, d);
    check_output("single_cnt1", DATA_W'(outst_cnt), DATA_W'(1));
    advance();
    bus.tcdm_r_valid_i = 1'b0;
    settle();
    check_output("single_cnt2", DATA_W'(outst_cnt), DATA_W'(0));
    advance();

    // Round-robin with all four requesters writing
    do_reset();
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    for (int i = 0; i < N_REQ; i++) apply_stimulus(i, 1'b0, ADDR_W'(32'h1000 * (i + 1)));
    bus.tcdm_gnt_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      check_output("rr_order", DATA_W'(bus.gnt_o), DATA_W'(rr_exp[c]));
      advance();
    end

    // Stall lock on W while X joins
    do_reset();
    apply_stimulus(1, 1'b0, 32'h2000);
    settle();
    check_output("lock_add1", DATA_W'(bus.tcdm_add_o), DATA_W'(32'h2000));
    advance();
    apply_stimulus(0, 1'b0, 32'h1000);
    for (int c = 0; c < 2; c++) begin
      settle();
      check_output("lock_add2", DATA_W'(bus.tcdm_add_o), DATA_W'(32'h2000));
      advance();
    end
    bus.tcdm_gnt_i = 1'b1;
    settle();
    check_output("lock_gnt_w", DATA_W'(bus.gnt_o), DATA_W'(4'b0010));
    advance();
    bus.req_i[1] = 1'b0;
    settle();
    check_output("lock_gnt_x", DATA_W'(bus.gnt_o), DATA_W'(4'b0001));
    advance();

    // FIFO full masks reads while the Z write proceeds
    do_reset();
    apply_stimulus(0, 1'b1, 32'h300);
    bus.tcdm_gnt_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      check_output("full_fill_gnt", DATA_W'(bus.gnt_o), DATA_W'(4'b0001));
      advance();
    end
    apply_stimulus(3, 1'b0, 32'h400);
    settle();
    check_output("full_cnt4", DATA_W'(outst_cnt), DATA_W'(4));
    check_output("full_gnt_z", DATA_W'(bus.gnt_o), DATA_W'(4'b1000));
    advance();
    bus.req_i[3] = 1'b0;
    bus.tcdm_r_valid_i = 1'b1; bus.tcdm_r_data_i = {9{32'h0BAD_F00D}};
    settle();
    check_output("full_masked", DATA_W'(bus.tcdm_req_o), DATA_W'(0));
    check_output("full_resp", DATA_W'(bus.r_valid_o), DATA_W'(4'b0001));
    advance();
    bus.tcdm_r_valid_i = 1'b0;
    settle();
    check_output("full_reissue", DATA_W'(bus.gnt_o), DATA_W'(4'b0001));
    check_output("full_cnt3", DATA_W'(outst_cnt), DATA_W'(3));
    advance();

    // Starvation escalation ahead of the round-robin pointer
    do_reset();
    apply_stimulus(2, 1'b0, 32'h2200);
    bus.tcdm_gnt_i = 1'b1;
    settle();
    check_output("starve_pre", DATA_W'(bus.gnt_o), DATA_W'(4'b0100));
    advance();
    enable = 1'b0;
    bus.tcdm_gnt_i = 1'b0;
    apply_stimulus(3, 1'b0, 32'h3300);
    for (int c = 0; c < STARVE_LIM; c++) begin
      settle();
      advance();
    end
    enable = 1'b1;
    bus.tcdm_gnt_i = 1'b1;
    apply_stimulus(0, 1'b0, 32'h0);
    settle();
    check_output("starve_y", DATA_W'(bus.gnt_o), DATA_W'(4'b0100));
    advance();
    settle();
    check_output("starve_z", DATA_W'(bus.gnt_o), DATA_W'(4'b1000));
    advance();
    settle();
    check_output("starve_x", DATA_W'(bus.gnt_o), DATA_W'(4'b0001));
    advance();

    // Stray response sets the sticky error
    do_reset();
    bus.tcdm_r_valid_i = 1'b1;
    settle();
    check_output("stray_rvalid", DATA_W'(bus.r_valid_o), DATA_W'(0));
    advance();
    bus.tcdm_r_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check_output("stray_err", DATA_W'(err), DATA_W'(1));
      advance();
    end
    do_reset();
    settle();
    check_output("stray_err_clr", DATA_W'(err), DATA_W'(0));
    advance();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < N_REQ; i++) pend[i] = 0;
    gnt_pct = 90;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) gnt_pct = (c / 250) % 3 == 0 ? 90 : ((c / 250) % 3 == 1 ? 50 : 15);
      for (int i = 0; i < N_REQ; i++) begin
        if (pend[i] && last_gnt[i]) pend[i] = 0;
        if (!pend[i] && $urandom_range(0, 99) < 40) begin
          pend[i]      = 1;
          bus.wen_i[i] = (i != 3);
          s_addr[i]    = ADDR_W'($urandom);
          s_be[i]      = BE_W'({$urandom, $urandom});
          s_wdata[i]   = rand_wide();
        end
        bus.req_i[i] = pend[i];
      end
      enable             = ($urandom_range(0, 99) < 92);
      bus.tcdm_gnt_i     = ($urandom_range(0, 99) < gnt_pct);
      bus.tcdm_r_valid_i = (m_q.size() > 0) && ($urandom_range(0, 99) < 50);
      bus.tcdm_r_data_i  = rand_wide();
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
